control_sequencer: RTL and testbench

Hardwired control unit that sits directly upstream of `datapath`. It steps through fetch (T0–T1) and execute (T2–T5) of register–register ALU instructions and drives every datapath strobe: register in/out selects, bus-source selects, ALU op one-hot, and memory read. It decodes the IR value loaded by the datapath and returns to fetch after each instruction, so the hand-written T-state stimulus is no longer needed.

---
 rtl/cpu_ctrl_pkg.sv | 44 ++++
 rtl/instr_decode.sv | 50 +++++
 rtl/control_sequencer.sv | 124 ++++++++++++
 tb/tb_control_sequencer.sv | 128 ++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// rtl/cpu_ctrl_pkg.sv - shared opcodes, state encoding and alu_op bit indices
package cpu_ctrl_pkg;

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ROR  = 5'b00111;
  localparam logic [4:0] OP_ROL  = 5'b01000;
  localparam logic [4:0] OP_SHR  = 5'b01001;
  localparam logic [4:0] OP_SHRA = 5'b01010;
  localparam logic [4:0] OP_SHL  = 5'b01011;
  localparam logic [4:0] OP_DIV  = 5'b01111;
  localparam logic [4:0] OP_MUL  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;

  localparam int ALU_AND  = 0;
  localparam int ALU_OR   = 1;
  localparam int ALU_ADD  = 2;
  localparam int ALU_SUB  = 3;
  localparam int ALU_MUL  = 4;
  localparam int ALU_DIV  = 5;
  localparam int ALU_SHR  = 6;
  localparam int ALU_SHRA = 7;
  localparam int ALU_SHL  = 8;
  localparam int ALU_ROR  = 9;
  localparam int ALU_ROL  = 10;
  localparam int ALU_NEG  = 11;
  localparam int ALU_NOT  = 12;
  localparam int ALU_W    = 13;

  typedef enum logic [2:0] {
    S_RESET = 3'd0,
    S_T0    = 3'd1,
    S_T1    = 3'd2,
    S_T2    = 3'd3,
    S_T3    = 3'd4,
    S_T4    = 3'd5,
    S_T5    = 3'd6,
    S_HALT  = 3'd7
  } state_t;

endpackage

// File: rtl/instr_decode.sv
// rtl/instr_decode.sv - combinational IR decode into ALU one-hot and register selects
module instr_decode
  import cpu_ctrl_pkg::*;
(
  input  logic [31:0]      ir,
  output logic [ALU_W-1:0] op_onehot,
  output logic             is_muldiv,
  output logic             is_unary,
  output logic             legal,
  output logic [15:0]      ra_sel,
  output logic [15:0]      rb_sel,
  output logic [15:0]      rc_sel
);

  // Low IR bits carry immediates for other instruction classes; not used here.
  logic ir_unused;
  assign ir_unused = ^ir[14:0];

  // Opcode to ALU one-hot and instruction class flags.
  always_comb begin
    op_onehot = '0;
    is_muldiv = 1'b0;
    is_unary  = 1'b0;
    legal     = 1'b1;
    unique case (ir[31:27])
      OP_ADD:  op_onehot[ALU_ADD]  = 1'b1;
      OP_SUB:  op_onehot[ALU_SUB]  = 1'b1;
      OP_AND:  op_onehot[ALU_AND]  = 1'b1;
      OP_OR:   op_onehot[ALU_OR]   = 1'b1;
      OP_ROR:  op_onehot[ALU_ROR]  = 1'b1;
      OP_ROL:  op_onehot[ALU_ROL]  = 1'b1;
      OP_SHR:  op_onehot[ALU_SHR]  = 1'b1;
      OP_SHRA: op_onehot[ALU_SHRA] = 1'b1;
      OP_SHL:  op_onehot[ALU_SHL]  = 1'b1;
      OP_DIV:  begin op_onehot[ALU_DIV] = 1'b1; is_muldiv = 1'b1; end
      OP_MUL:  begin op_onehot[ALU_MUL] = 1'b1; is_muldiv = 1'b1; end
      OP_NEG:  begin op_onehot[ALU_NEG] = 1'b1; is_unary  = 1'b1; end
      OP_NOT:  begin op_onehot[ALU_NOT] = 1'b1; is_unary  = 1'b1; end
      default: legal = 1'b0;
    endcase
  end

  // Register field one-hot selects.
  always_comb begin
    ra_sel = 16'h0001 << ir[26:23];
    rb_sel = 16'h0001 << ir[22:19];
    rc_sel = 16'h0001 << ir[18:15];
  end

endmodule

// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - hardwired fetch/execute sequencer driving datapath strobes
module control_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int PC_RESET_HOLD = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic [31:0]      IR,
  output logic [15:0]      Rout,
  output logic [15:0]      Rin,
  output logic             PCout,
  output logic             PCin,
  output logic             IncPC,
  output logic             MARin,
  output logic             MDRin,
  output logic             MDRout,
  output logic             Read,
  output logic             IRin,
  output logic             Yin,
  output logic             Zin,
  output logic             Zlowout,
  output logic             Zhighout,
  output logic             HIin,
  output logic             LOin,
  output logic [ALU_W-1:0] alu_op,
  output logic             instr_done,
  output logic             illegal,
  output logic [15:0]      instr_count
);

  localparam logic [1:0] HOLD_LAST = 2'(PC_RESET_HOLD - 1);

  state_t             state_q, state_d;
  logic [1:0]         hold_q, hold_d;
  logic [15:0]        count_q, count_d;
  logic [ALU_W-1:0]   op_onehot;
  logic               is_muldiv, is_unary, legal;
  logic [15:0]        ra_sel, rb_sel, rc_sel;

  instr_decode u_decode (
    .ir        (IR),
    .op_onehot (op_onehot),
    .is_muldiv (is_muldiv),
    .is_unary  (is_unary),
    .legal     (legal),
    .ra_sel    (ra_sel),
    .rb_sel    (rb_sel),
    .rc_sel    (rc_sel)
  );

  // State, reset-hold counter and retired-instruction counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_RESET;
      hold_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      count_q <= count_d;
    end
  end

  // Next state; instruction boundaries are the only places run is honoured.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    unique case (state_q)
      S_RESET: begin
        if (hold_q == HOLD_LAST) state_d = run ? S_T0 : S_HALT;
        else                     hold_d  = hold_q + 2'd1;
      end
      S_T0:   state_d = S_T1;
      S_T1:   state_d = S_T2;
      S_T2:   state_d = legal ? S_T3 : (run ? S_T0 : S_HALT);
      S_T3:   state_d = S_T4;
      S_T4:   state_d = is_muldiv ? S_T5 : (run ? S_T0 : S_HALT);
      S_T5:   state_d = run ? S_T0 : S_HALT;
      S_HALT: state_d = run ? S_T0 : S_HALT;
      default: state_d = S_RESET;
    endcase
  end

  // Moore strobe decode from present state and IR; all quiet while reset is high.
  always_comb begin
    Rout = '0; Rin = '0; alu_op = '0;
    PCout = 1'b0; PCin = 1'b0; IncPC = 1'b0; MARin = 1'b0; MDRin = 1'b0;
    MDRout = 1'b0; Read = 1'b0; IRin = 1'b0; Yin = 1'b0; Zin = 1'b0;
    Zlowout = 1'b0; Zhighout = 1'b0; HIin = 1'b0; LOin = 1'b0;
    instr_done = 1'b0; illegal = 1'b0;
    if (!reset) begin
      unique case (state_q)
        S_T0: begin IncPC = 1'b1; PCin = 1'b1; MARin = 1'b1; Read = 1'b1; MDRin = 1'b1; end
        S_T1: begin MDRout = 1'b1; IRin = 1'b1; end
        S_T2: begin
          if (legal) begin Rout = rb_sel; Yin = 1'b1; end
          else illegal = 1'b1;
        end
        S_T3: begin
          Rout   = is_unary ? rb_sel : rc_sel;
          alu_op = op_onehot;
          Zin    = 1'b1;
        end
        S_T4: begin
          Zlowout = 1'b1;
          if (is_muldiv) LOin = 1'b1;
          else begin Rin = ra_sel; instr_done = 1'b1; end
        end
        S_T5: begin Zhighout = 1'b1; HIin = 1'b1; instr_done = 1'b1; end
        default: ;
      endcase
    end
  end

  // Count retires on the edge closing an instr_done cycle; wraps naturally.
  always_comb begin
    count_d = count_q + {15'd0, instr_done};
  end

  assign instr_count = count_q;

endmodule

// File: tb/tb_control_sequencer.sv
// tb/tb_control_sequencer.sv - directed self-checking bench for control_sequencer
module tb_control_sequencer;

  logic        clk = 1'b0;
  logic        reset, run;
  logic [31:0] IR;
  logic [15:0] Rout, Rin, instr_count;
  logic        PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, IRin;
  logic        Yin, Zin, Zlowout, Zhighout, HIin, LOin, instr_done, illegal;
  logic [12:0] alu_op;

  int total  = 0;
  int passed = 0;

  // Strobe bit masks within the packed strobe vector built below.
  localparam logic [15:0] ST_T0   = 16'h7A00;
  localparam logic [15:0] ST_T1   = 16'h0500;
  localparam logic [15:0] ST_YIN  = 16'h0080;
  localparam logic [15:0] ST_ZIN  = 16'h0040;
  localparam logic [15:0] ST_T4A  = 16'h0022;
  localparam logic [15:0] ST_T4M  = 16'h0024;
  localparam logic [15:0] ST_T5   = 16'h001A;
  localparam logic [15:0] ST_ILL  = 16'h0001;
  localparam logic [15:0] ST_NONE = 16'h0000;

  control_sequencer #(.PC_RESET_HOLD(1)) dut (
    .clk(clk), .reset(reset), .run(run), .IR(IR),
    .Rout(Rout), .Rin(Rin), .PCout(PCout), .PCin(PCin), .IncPC(IncPC),
    .MARin(MARin), .MDRin(MDRin), .MDRout(MDRout), .Read(Read), .IRin(IRin),
    .Yin(Yin), .Zin(Zin), .Zlowout(Zlowout), .Zhighout(Zhighout),
    .HIin(HIin), .LOin(LOin), .alu_op(alu_op), .instr_done(instr_done),
    .illegal(illegal), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] strobes();
    return {PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, IRin,
            Yin, Zin, Zlowout, Zhighout, HIin, LOin, instr_done, illegal};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic chk_out(input string tag, input logic [15:0] st, input logic [15:0] ro,
                         input logic [15:0] ri, input logic [12:0] alu);
    chk({tag, ".strobes"}, {16'd0, strobes()}, {16'd0, st});
    chk({tag, ".Rout"},    {16'd0, Rout},      {16'd0, ro});
    chk({tag, ".Rin"},     {16'd0, Rin},       {16'd0, ri});
    chk({tag, ".alu_op"},  {19'd0, alu_op},    {19'd0, alu});
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; run = 1'b1; IR = 32'h4A1B8000;
    repeat (3) step();
    chk_out("reset", ST_NONE, 16'h0, 16'h0, 13'h0);
    chk("reset.count", {16'd0, instr_count}, 32'd0);

    reset = 1'b0;
    chk_out("hold", ST_NONE, 16'h0, 16'h0, 13'h0);
    step(); chk_out("shr.T0", ST_T0, 16'h0, 16'h0, 13'h0);
    step(); chk_out("shr.T1", ST_T1, 16'h0, 16'h0, 13'h0);
    step(); chk_out("shr.T2", ST_YIN, 16'h0008, 16'h0, 13'h0);
    step(); chk_out("shr.T3", ST_ZIN, 16'h0080, 16'h0, 13'h0040);
    step(); chk_out("shr.T4", ST_T4A, 16'h0, 16'h0010, 13'h0);
    chk("shr.T4.count", {16'd0, instr_count}, 32'd0);

    step(); chk_out("mul.T0", ST_T0, 16'h0, 16'h0, 13'h0);
    chk("shr.count", {16'd0, instr_count}, 32'd1);
    IR = 32'h801B8000;
    step(); chk_out("mul.T1", ST_T1, 16'h0, 16'h0, 13'h0);
    step(); chk_out("mul.T2", ST_YIN, 16'h0008, 16'h0, 13'h0);
    step(); chk_out("mul.T3", ST_ZIN, 16'h0080, 16'h0, 13'h0010);
    step(); chk_out("mul.T4", ST_T4M, 16'h0, 16'h0, 13'h0);
    step(); chk_out("mul.T5", ST_T5, 16'h0, 16'h0, 13'h0);

    step(); chk_out("neg.T0", ST_T0, 16'h0, 16'h0, 13'h0);
    chk("mul.count", {16'd0, instr_count}, 32'd2);
    IR = 32'h8A180000;
    step(); chk_out("neg.T1", ST_T1, 16'h0, 16'h0, 13'h0);
    step(); chk_out("neg.T2", ST_YIN, 16'h0008, 16'h0, 13'h0);
    step(); chk_out("neg.T3", ST_ZIN, 16'h0008, 16'h0, 13'h0800);
    step(); chk_out("neg.T4", ST_T4A, 16'h0, 16'h0010, 13'h0);

    step(); chk_out("ill.T0", ST_T0, 16'h0, 16'h0, 13'h0);
    chk("neg.count", {16'd0, instr_count}, 32'd3);
    IR = 32'h00000000;
    step(); chk_out("ill.T1", ST_T1, 16'h0, 16'h0, 13'h0);
    step(); chk_out("ill.T2", ST_ILL, 16'h0, 16'h0, 13'h0);

    step(); chk_out("stop.T0", ST_T0, 16'h0, 16'h0, 13'h0);
    chk("ill.count", {16'd0, instr_count}, 32'd3);
    IR = 32'h4A1B8000;
    step(); chk_out("stop.T1", ST_T1, 16'h0, 16'h0, 13'h0);
    step(); chk_out("stop.T2", ST_YIN, 16'h0008, 16'h0, 13'h0);
    step(); chk_out("stop.T3", ST_ZIN, 16'h0080, 16'h0, 13'h0040);
    run = 1'b0;
    step(); chk_out("stop.T4", ST_T4A, 16'h0, 16'h0010, 13'h0);
    step(); chk_out("halt.0", ST_NONE, 16'h0, 16'h0, 13'h0);
    chk("halt.count", {16'd0, instr_count}, 32'd4);
    step(); chk_out("halt.1", ST_NONE, 16'h0, 16'h0, 13'h0);

    reset = 1'b1;
    step(); chk("reset2.count", {16'd0, instr_count}, 32'd0);
    chk_out("reset2", ST_NONE, 16'h0, 16'h0, 13'h0);
    reset = 1'b0;
    step(); chk_out("hold2", ST_NONE, 16'h0, 16'h0, 13'h0);
    step(); chk_out("halt2", ST_NONE, 16'h0, 16'h0, 13'h0);
    run = 1'b1;
    step(); chk_out("wake.T0", ST_T0, 16'h0, 16'h0, 13'h0);
    step(); chk_out("wake.T1", ST_T1, 16'h0, 16'h0, 13'h0);
    step(); chk_out("wake.T2", ST_YIN, 16'h0008, 16'h0, 13'h0);
    reset = 1'b1;
    step(); chk_out("abort", ST_NONE, 16'h0, 16'h0, 13'h0);
    chk("abort.count", {16'd0, instr_count}, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
